// File: rtl/exec_replica_monitor.sv
// Drives the execute-stage inverter-chain replica, checks that each launch returns within
// one clock, and reports windowed violation counts through a valid/ready result port.
module exec_replica_monitor #(
  parameter int WINDOW = 256,
  parameter int THRESH = 1,
  parameter bit INVERT = 1'b0,
  parameter int SETTLE = 2,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic             clear_alarm,
  output logic             rep_launch,
  input  logic             rep_return,
  output logic             err_pulse,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_alarm,
  output logic             alarm_sticky
);

  localparam int PH_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE - 1);
  localparam logic [PH_W-1:0]  WINDOW_LAST = PH_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(THRESH);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

  state_t           state, state_next;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] count, count_inc;
  logic             samp_q, exp_q, mismatch;
  logic             toggle, counting, window_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ARM;
      ARM:     if (abort) state_next = IDLE;
               else if (phase == SETTLE_LAST) state_next = MEASURE;
      MEASURE: if (abort) state_next = IDLE;
               else if (phase == WINDOW_LAST) state_next = REPORT;
      REPORT:  if (res_ready) state_next = continuous ? ARM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    res_valid   = (state == REPORT);
    toggle      = (state == ARM) || (state == MEASURE);
    counting    = (state == MEASURE);
    window_done = counting && !abort && (phase == WINDOW_LAST);
  end

  // Phase restarts on every state change so ARM and MEASURE each count from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              phase <= '0;
    else if ((state_next != state) || !toggle) phase <= '0;
    else                                     phase <= phase + 1'b1;
  end

  // exp_q lags the launch by one edge so it lines up with the sampled return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_launch <= 1'b0;
      exp_q      <= 1'b0;
      samp_q     <= 1'b0;
    end else begin
      exp_q  <= rep_launch ^ INVERT;
      samp_q <= rep_return;
      if (toggle) rep_launch <= ~rep_launch;
    end
  end

  assign mismatch = (samp_q != exp_q);

  always_comb begin
    count_inc = count;
    if (count != CNT_MAX) count_inc = count + CNT_W'(mismatch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= counting && mismatch;
      count     <= counting ? count_inc : '0;
    end
  end

  // A new alarm outranks a simultaneous clear request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_count    <= '0;
      res_alarm    <= 1'b0;
      alarm_sticky <= 1'b0;
    end else begin
      if (window_done) begin
        res_count <= count_inc;
        res_alarm <= (count_inc >= THRESH_C);
      end
      if (window_done && (count_inc >= THRESH_C)) alarm_sticky <= 1'b1;
      else if (clear_alarm)                      alarm_sticky <= 1'b0;
    end
  end

endmodule

// File: doc/exec_replica_monitor.md
Name: exec_replica_monitor

Overview:
Timing monitor that drives and consumes the execute-stage critical-path inverter-chain replica. It toggles the replica input every measurement cycle, samples the replica output one clock later, and flags late arrival as a timing violation. Violations are counted over a programmable window, and the result is reported through a valid/ready handshake to the error-resilience controller. A sticky alarm is raised when a window's count reaches threshold.

Parameters:
WINDOW, 256, number of compare cycles per measurement window (>=1)
THRESH, 1, violation count at or above which res_alarm/alarm_sticky assert (1..WINDOW)
INVERT, 0, 1 if replica chain has odd inversion count (expected return = launch ^ INVERT)
SETTLE, 2, ARM cycles before comparisons are counted (>=2)
CNT_W, $clog2(WINDOW+1), width of violation counter

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a measurement; honoured in IDLE only
abort  in  1  abandon ARM/MEASURE, return to IDLE, no report
continuous  in  1  sampled at result handshake; 1 -> rearm immediately
clear_alarm  in  1  clears alarm_sticky (set has priority if same cycle)
rep_launch  out  1  registered drive into replica input
rep_return  in  1  replica output (async to launch, sampled on clk)
err_pulse  out  1  one-cycle pulse per counted violation
busy  out  1  high in ARM, MEASURE, REPORT
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_count  out  CNT_W  violations in completed window
res_alarm  out  1  res_count >= THRESH
alarm_sticky  out  1  latched alarm across windows

Behaviour:
- Reset (async, rst_n=0): state IDLE; rep_launch=0, samp/exp regs=0, counter=0, err_pulse=0, busy=0, res_valid=0, res_count=0, res_alarm=0, alarm_sticky=0.
- FSM states: IDLE, ARM, MEASURE, REPORT.
- IDLE: rep_launch holds; start=1 -> ARM, counter cleared, phase counter cleared.
- ARM: SETTLE cycles; rep_launch toggles every cycle; comparisons ignored; -> MEASURE.
- MEASURE: WINDOW cycles; rep_launch keeps toggling; each cycle one comparison counted; after WINDOW-th comparison -> REPORT, res_count/res_alarm loaded, res_valid=1.
- REPORT: rep_launch holds; outputs stable while res_valid && !res_ready. Handshake (res_valid&&res_ready): res_valid drops next cycle; continuous=1 -> ARM (counter cleared) else IDLE.
- Compare pipeline: posedge k updates rep_launch to L_k and exp_q <= L_{k-1}^INVERT; posedge k+1 samp_q <= rep_return; exp_q then holds L_k^INVERT; posedge k+2 err = samp_q != exp_q. Pipeline latency 2 cycles; SETTLE>=2 guarantees every counted comparison refers to a toggled launch.
- err_pulse registered, asserted only for comparisons counted in MEASURE.
- Counter saturates at WINDOW (cannot exceed by construction; saturation enforced anyway).
- alarm_sticky set on entering REPORT with res_alarm=1; cleared by clear_alarm only; set wins over simultaneous clear.
- abort in ARM/MEASURE -> IDLE next cycle, counter cleared, no res_valid, alarm unchanged. abort ignored in IDLE/REPORT.
- start ignored when not IDLE; start and abort same cycle in IDLE -> start wins (abort no effect in IDLE).
- Reset mid-operation: immediate return to reset values, no partial report.
- busy = (state != IDLE).

Test Plan:
- Replica model delay 0.5 clk, WINDOW=16, THRESH=1: start -> res_valid 18+1 cycles later, res_count=0, res_alarm=0, err_pulse never high.
- Replica delay 1.5 clk (sample sees previous launch): res_count=16, err_pulse high 16 consecutive cycles, res_alarm=1, alarm_sticky=1; clear_alarm -> alarm_sticky=0.
- res_ready held low 10 cycles in REPORT: res_valid, res_count, res_alarm stable, rep_launch frozen; ready=1 -> res_valid=0 next cycle, state IDLE.
- continuous=1 at handshake: busy stays 1, next window starts, second result reported without start; INVERT=1 with inverting model gives count 0.
- abort at MEASURE cycle 5: IDLE next cycle, res_valid never asserts, counter 0; start again gives full clean window.
- rst_n low mid-MEASURE with alarm_sticky=1: all outputs to reset values asynchronously; clear_alarm and res_alarm same cycle as set -> sticky remains 1.
